stream_compressor: RTL and testbench

Parametrised, self-contained successor to the fixed 8×32-bit compressor pipeline. It accepts NUM_DATA-word beats over a ready/valid handshake and classifies each word into one of four size classes. It emits one variable-length record per beat and packs the records LSB-first into a continuous stream of fixed-width output beats. Full backpressure is supported in both directions, and an explicit end-of-stream flush emits a final partial beat with a valid-bit count.

---
 rtl/stream_compressor.sv | 178 +++++++++++++++++
 tb/tb_stream_compressor.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_compressor.sv
// stream_compressor: classifies NUM_DATA-word beats into tagged variable-length
// records and packs them LSB-first into fixed-width output beats. A beat
// flagged in_last causes a flush that emits a final partial beat with a
// valid-bit count.
module stream_compressor #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_DATA   = 8,
  localparam int OUT_W      = DATA_WIDTH * NUM_DATA,
  localparam int CNT_W      = $clog2(OUT_W) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wrt_en,
  input  logic [DATA_WIDTH*NUM_DATA-1:0] in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [OUT_W-1:0]               out_data,
  output logic                           out_valid,
  output logic                           out_last,
  output logic [CNT_W-1:0]               out_count,
  input  logic                           out_ready
);

  // Record = header (two tag bits per word) followed by the packed payloads.
  localparam int HDR_W = 2 * NUM_DATA;
  localparam int REC_W = OUT_W + HDR_W;
  // Worst-case fill: just under OUT_W bits plus one maximal record.
  localparam int BUF_W = 2 * OUT_W + HDR_W;
  localparam int FW    = $clog2(BUF_W + 1);

  localparam logic [FW-1:0]    OUT_W_F = FW'(OUT_W);
  localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);

  // Per-word classification results
  logic [1:0]            tag_w  [NUM_DATA];
  logic [DATA_WIDTH-1:0] pay_w  [NUM_DATA];
  logic [FW-1:0]         plen_w [NUM_DATA];

  // Record assembled from the incoming beat
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] pay_ext;
  logic [FW-1:0]    len_in;

  // Stage 1: one classified record waiting for the packer
  logic             s1_valid_q, s1_valid_d;
  logic [REC_W-1:0] s1_rec_q,   s1_rec_d;
  logic [FW-1:0]    s1_len_q,   s1_len_d;
  logic             s1_last_q,  s1_last_d;

  // Stage 2: packing buffer, fill count and pending flush
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [BUF_W-1:0] buf_ext;
  logic [FW-1:0]    f_q,   f_d;
  logic             flush_q, flush_d;

  logic f_ge;
  logic append;
  logic emit;
  logic s1_take;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DATA; gi++) begin : g_word
      logic [DATA_WIDTH-1:0] word;
      logic                  is_zero;
      logic                  is_s8;
      logic                  is_s16;

      assign word    = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign is_zero = (word == '0);
      assign is_s8   = (word == {{(DATA_WIDTH-8){word[7]}}, word[7:0]});
      assign is_s16  = (word == {{(DATA_WIDTH-16){word[15]}}, word[15:0]});

      // First matching class wins: zero, 8-bit signed, 16-bit signed, full.
      assign tag_w[gi]  = is_zero ? 2'b00 : is_s8 ? 2'b01 : is_s16 ? 2'b10 : 2'b11;
      assign pay_w[gi]  = is_zero ? '0 :
                          is_s8   ? {{(DATA_WIDTH-8){1'b0}}, word[7:0]} :
                          is_s16  ? {{(DATA_WIDTH-16){1'b0}}, word[15:0]} :
                                    word;
      assign plen_w[gi] = is_zero ? FW'(0) :
                          is_s8   ? FW'(8) :
                          is_s16  ? FW'(16) :
                                    FW'(DATA_WIDTH);
    end
  endgenerate

  // Build the record: header in the low bits, then payloads back to back.
  always_comb begin
    rec_in  = '0;
    pay_ext = '0;
    len_in  = FW'(HDR_W);
    for (int i = 0; i < NUM_DATA; i++) begin
      pay_ext                   = '0;
      pay_ext[DATA_WIDTH-1:0]   = pay_w[i];
      rec_in[2*i +: 2]          = tag_w[i];
      rec_in                    = rec_in | (pay_ext << len_in);
      len_in                    = len_in + plen_w[i];
    end
  end

  // Handshake and append/emit decisions. Append needs F below one beat and
  // no flush in progress; emit needs a full beat or a pending flush, so the
  // two are mutually exclusive.
  assign f_ge      = (f_q >= OUT_W_F);
  assign append    = wrt_en && s1_valid_q && !f_ge && !flush_q;
  assign out_valid = wrt_en && (f_ge || (flush_q && (f_q != '0)));
  assign emit      = out_valid && out_ready;
  assign in_ready  = wrt_en && (!s1_valid_q || append);
  assign s1_take   = in_valid && in_ready;

  assign out_data  = buf_q[OUT_W-1:0];
  assign out_count = out_valid ? (f_ge ? OUT_W_C : f_q[CNT_W-1:0]) : '0;
  assign out_last  = out_valid && flush_q && (f_q <= OUT_W_F);

  // Stage 1 loads on a handshake and empties when the packer takes it.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_rec_d   = s1_rec_q;
    s1_len_d   = s1_len_q;
    s1_last_d  = s1_last_q;
    if (s1_take) begin
      s1_valid_d = 1'b1;
      s1_rec_d   = rec_in;
      s1_len_d   = len_in;
      s1_last_d  = in_last;
    end else if (append) begin
      s1_valid_d = 1'b0;
    end
  end

  // Packer: OR the record in at offset F, or shift out one beat on emit.
  always_comb begin
    buf_d                = buf_q;
    f_d                  = f_q;
    flush_d              = flush_q;
    buf_ext              = '0;
    buf_ext[REC_W-1:0]   = s1_rec_q;
    if (append) begin
      buf_d = buf_q | (buf_ext << f_q);
      f_d   = f_q + s1_len_q;
      if (s1_last_q) begin
        flush_d = 1'b1;
      end
    end else if (emit) begin
      buf_d = buf_q >> OUT_W;
      if (f_q > OUT_W_F) begin
        f_d = f_q - OUT_W_F;
      end else begin
        // Final beat of a flush, or an exactly-full beat: buffer is now empty.
        f_d     = '0;
        flush_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; wrt_en=0 leaves all _d == _q.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_rec_q   <= '0;
      s1_len_q   <= '0;
      s1_last_q  <= 1'b0;
      buf_q      <= '0;
      f_q        <= '0;
      flush_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_rec_q   <= s1_rec_d;
      s1_len_q   <= s1_len_d;
      s1_last_q  <= s1_last_d;
      buf_q      <= buf_d;
      f_q        <= f_d;
      flush_q    <= flush_d;
    end
  end

endmodule

// File: tb/tb_stream_compressor.sv
// Testbench for stream_compressor: directed vector table, two-beat flush
// sequence, randomized stream against a bit-queue reference model, and a
// reset-during-stall recovery sequence.
module tb_stream_compressor;
  localparam int DW = 32;
  localparam int ND = 8;
  localparam int OW = DW * ND;
  localparam int CW = $clog2(OW) + 1;
  localparam int NB = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          wrt_en;
  logic [OW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic [CW-1:0] out_count;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;

  stream_compressor #(.DATA_WIDTH(DW), .NUM_DATA(ND)) dut (
    .clk       (clk),
    .reset     (reset),
    .wrt_en    (wrt_en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_count (out_count),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] din;
    logic [OW-1:0] exp_data;
    int            exp_count;
  } vec_t;

  typedef struct {
    logic [OW-1:0] data;
    int            count;
    bit            last;
  } obeat_t;

  typedef struct {
    logic [OW-1:0] data;
    bit            last;
  } ibeat_t;

  vec_t   vecs[3];
  obeat_t exp_q[$];
  bit     sbits[$];
  ibeat_t stim[$];

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: serialise each beat into a stream bit queue from the
  // classification rules, then cut the stream into OW-bit output beats.
  task automatic model_push(input logic [OW-1:0] d, input bit last);
    logic [DW-1:0] ws [ND];
    int            tags [ND];
    int            lens [ND];
    int            sv;
    int            n;
    obeat_t        ob;
    for (int i = 0; i < ND; i++) begin
      ws[i] = d[i*DW +: DW];
      sv    = $signed(ws[i]);
      if (sv == 0) begin
        tags[i] = 0; lens[i] = 0;
      end else if (sv >= -128 && sv <= 127) begin
        tags[i] = 1; lens[i] = 8;
      end else if (sv >= -32768 && sv <= 32767) begin
        tags[i] = 2; lens[i] = 16;
      end else begin
        tags[i] = 3; lens[i] = DW;
      end
    end
    for (int i = 0; i < ND; i++) begin
      sbits.push_back(bit'(tags[i] % 2));
      sbits.push_back(bit'(tags[i] / 2));
    end
    for (int i = 0; i < ND; i++) begin
      for (int b = 0; b < lens[i]; b++) begin
        sbits.push_back(ws[i][b]);
      end
    end
    if (last) begin
      while (sbits.size() > 0) begin
        n       = (sbits.size() > OW) ? OW : sbits.size();
        ob.data = '0;
        for (int b = 0; b < n; b++) ob.data[b] = sbits.pop_front();
        ob.count = n;
        ob.last  = (sbits.size() == 0);
        exp_q.push_back(ob);
      end
    end else begin
      while (sbits.size() >= OW) begin
        ob.data = '0;
        for (int b = 0; b < OW; b++) ob.data[b] = sbits.pop_front();
        ob.count = OW;
        ob.last  = 1'b0;
        exp_q.push_back(ob);
      end
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [7:0]  b8;
    logic [15:0] b16;
    case ($urandom_range(0, 3))
      0: return '0;
      1: begin b8 = 8'($urandom); return {{(DW-8){b8[7]}}, b8}; end
      2: begin b16 = 16'($urandom); return {{(DW-16){b16[15]}}, b16}; end
      default: return $urandom;
    endcase
  endfunction

  // Offer one beat with out_ready held low until the block accepts it.
  task automatic send_beat(input logic [OW-1:0] d, input bit last);
    bit done;
    done = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    in_data   = d;
    in_last   = last;
    in_valid  = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (in_ready) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_beat: got in_ready=0 for 100 cycles expected acceptance");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Raise out_ready and capture the next output beat (consumed at the next edge).
  task automatic get_beat(output logic [OW-1:0] d, output int c, output bit l, output bit ok);
    ok = 1'b0;
    d  = '0;
    c  = 0;
    l  = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        d  = out_data;
        c  = int'(out_count);
        l  = out_last;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL get_beat: got no out_valid in 200 cycles expected a beat");
    end
  endtask

  initial begin
    logic [OW-1:0] d;
    logic [OW-1:0] d80;
    logic [OW-1:0] held;
    int            c;
    bit            l;
    bit            ok;
    bit            hold;
    bit            stalled;
    int            idx;
    int            got;
    int            cycles;
    int            exp_cnt[3];

    vecs[0].din       = '0;
    vecs[0].exp_data  = '0;
    vecs[0].exp_count = 16;
    vecs[1].din       = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vecs[1].exp_data  = {176'h0, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 16'h5555};
    vecs[1].exp_count = 80;
    vecs[2].din       = {32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h0000007F,
                         32'h00008000, 32'hFFFF8000, 32'h00000080, 32'hFFFFFF80};
    vecs[2].exp_data  = {120'h0, 32'h12345678, 8'hFF, 8'h7F, 32'h00008000,
                         16'h8000, 16'h0080, 8'h80, 16'hC5E9};
    vecs[2].exp_count = 136;

    reset     = 1'b1;
    wrt_en    = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_count", out_count, 0);
    end
    chk("reset_out_data", out_data, 0);
    chk("reset_out_last", out_last, 0);

    // Single-beat streams from the vector table
    for (int v = 0; v < 3; v++) begin
      send_beat(vecs[v].din, 1'b1);
      get_beat(d, c, l, ok);
      if (ok) begin
        chk($sformatf("vec%0d_data", v), d, vecs[v].exp_data);
        chk($sformatf("vec%0d_count", v), c, vecs[v].exp_count);
        chk($sformatf("vec%0d_last", v), l, 1);
        $display("vec%0d: out_count=%0d out_last=%0d out_data=%h", v, c, l, d);
      end
    end

    // Two maximal records: 544 bits split 256/256/32
    d80 = {ND{32'h80000000}};
    exp_q.delete();
    sbits.delete();
    model_push(d80, 1'b0);
    model_push(d80, 1'b1);
    exp_cnt = '{256, 256, 32};
    send_beat(d80, 1'b0);
    send_beat(d80, 1'b1);
    for (int k = 0; k < 3; k++) begin
      get_beat(d, c, l, ok);
      if (ok) begin
        chk($sformatf("two_beat%0d_count", k), c, exp_cnt[k]);
        chk($sformatf("two_beat%0d_last", k), l, (k == 2) ? 1 : 0);
        if (k < exp_q.size()) chk($sformatf("two_beat%0d_data", k), d, exp_q[k].data);
        $display("two_beat%0d: out_count=%0d out_last=%0d", k, c, l);
      end
    end

    // Randomized stream with backpressure and enable toggling
    exp_q.delete();
    sbits.delete();
    stim.delete();
    for (int i = 0; i < NB; i++) begin
      ibeat_t ib;
      for (int w = 0; w < ND; w++) ib.data[w*DW +: DW] = rand_word();
      ib.last = ($urandom_range(0, 39) == 0) || (i == NB - 1);
      stim.push_back(ib);
      model_push(ib.data, ib.last);
    end
    @(negedge clk);
    idx    = 0;
    got    = 0;
    cycles = 0;
    hold   = 1'b0;
    held   = '0;
    while ((idx < NB || got < exp_q.size()) && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      wrt_en    = ($urandom_range(0, 9) != 0);
      out_ready = 1'($urandom_range(0, 1));
      if (idx < NB) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = stim[idx].data;
        in_last  = stim[idx].last;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #1;
      if (!wrt_en) begin
        chk("rand_disabled_ready", in_ready, 0);
        chk("rand_disabled_valid", out_valid, 0);
      end
      if (hold && out_valid) chk("rand_hold_data", out_data, held);
      hold = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (got < exp_q.size()) begin
          chk($sformatf("rand_beat%0d_data", got), out_data, exp_q[got].data);
          chk($sformatf("rand_beat%0d_count", got), out_count, exp_q[got].count);
          chk($sformatf("rand_beat%0d_last", got), out_last, exp_q[got].last);
          if (out_last) $display("rand stream end at beat %0d: out_count=%0d", got, out_count);
        end else begin
          checks++;
          failures++;
          $display("FAIL rand_extra_beat: got beat %0d expected only %0d", got, exp_q.size());
        end
        got++;
      end
    end
    if (idx < NB || got < exp_q.size()) begin
      checks++;
      failures++;
      $display("FAIL rand_timeout: got %0d in/%0d out expected %0d in/%0d out", idx, got, NB, exp_q.size());
    end
    $display("rand: %0d beats in, %0d beats out in %0d cycles", idx, got, cycles);

    // Reset during a stall, then a fresh stream must start at bit 0
    @(negedge clk);
    wrt_en    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    stalled   = 1'b0;
    for (int n = 0; n < 20 && !stalled; n++) begin
      @(negedge clk);
      in_data  = d80;
      in_last  = 1'b0;
      in_valid = 1'b1;
      #1;
      if (!in_ready) stalled = 1'b1;
    end
    chk("stall_reached", stalled, 1);
    chk("stall_out_valid", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_out_valid", out_valid, 0);
    chk("post_reset_in_ready", in_ready, 1);
    reset = 1'b0;
    send_beat(vecs[1].din, 1'b1);
    get_beat(d, c, l, ok);
    if (ok) begin
      chk("after_reset_data", d, vecs[1].exp_data);
      chk("after_reset_count", c, vecs[1].exp_count);
      chk("after_reset_last", l, 1);
      $display("after_reset: out_count=%0d out_last=%0d", c, l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
